// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle processor control path:
// opcode map, ALU/SP operation codes, FSM state encoding and decode flags.
package cpu_pkg;

    localparam int OPW             = 5;
    localparam int FNW             = 4;
    localparam int MEM_TMO_DEFAULT = 15;

    localparam logic [OPW-1:0] OP_RTYPE = 5'b00000;
    localparam logic [OPW-1:0] OP_ADDI  = 5'b00001;
    localparam logic [OPW-1:0] OP_LW    = 5'b00010;
    localparam logic [OPW-1:0] OP_SW    = 5'b00011;
    localparam logic [OPW-1:0] OP_BEQZ  = 5'b00100;
    localparam logic [OPW-1:0] OP_J     = 5'b00101;
    localparam logic [OPW-1:0] OP_PUSH  = 5'b00110;
    localparam logic [OPW-1:0] OP_POP   = 5'b00111;
    localparam logic [OPW-1:0] OP_CALL  = 5'b01000;
    localparam logic [OPW-1:0] OP_RET   = 5'b01001;
    localparam logic [OPW-1:0] OP_HALT  = 5'b11111;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLT = 4'd5;

    localparam logic [3:0] SP_ADD = 4'd0;
    localparam logic [3:0] SP_SUB = 4'd1;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_SPADJ  = 3'd5,
        ST_HALT   = 3'd6,
        ST_ERR    = 3'd7
    } state_t;

    // One-hot instruction class; exactly one bit is set for any opcode.
    typedef struct packed {
        logic rtype;
        logic addi;
        logic lw;
        logic sw;
        logic beqz;
        logic j;
        logic push;
        logic pop;
        logic call;
        logic ret;
        logic halt;
        logic illegal;
    } instr_class_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: instruction-class flags plus the main ALU
// operation used in EXEC (funct passes straight through for R-type).
module ctrl_decode
    import cpu_pkg::*;
(
    input  logic [OPW-1:0] opcode,
    input  logic [FNW-1:0] funct,
    output instr_class_t   cls,
    output logic [3:0]     alu_op
);

    always_comb begin
        cls    = '0;
        alu_op = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                cls.rtype = 1'b1;
                alu_op    = funct;
            end
            OP_ADDI: cls.addi = 1'b1;
            OP_LW:   cls.lw   = 1'b1;
            OP_SW:   cls.sw   = 1'b1;
            OP_BEQZ: begin
                cls.beqz = 1'b1;
                alu_op   = ALU_SUB;
            end
            OP_J:    cls.j    = 1'b1;
            OP_PUSH: cls.push = 1'b1;
            OP_POP:  cls.pop  = 1'b1;
            OP_CALL: cls.call = 1'b1;
            OP_RET:  cls.ret  = 1'b1;
            OP_HALT: cls.halt = 1'b1;
            default: cls.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB (+SPADJ),
// watches the memory handshake for timeouts and drives all datapath controls.
module control_fsm
    import cpu_pkg::*;
#(
    parameter int MEM_TMO = MEM_TMO_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] opcode,
    input  logic [3:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       pc_write,
    output logic       regWrite,
    output logic       spWrite,
    output logic       regDst,
    output logic       aluSrc,
    output logic       memRead,
    output logic       memWrite,
    output logic       memToReg,
    output logic       jump,
    output logic       bAndZ,
    output logic       addrOp,
    output logic       aOp2,
    output logic       writeDataOp,
    output logic       wdOp2,
    output logic       pcOp,
    output logic [3:0] aluOp,
    output logic [3:0] spOp,
    output logic       halted,
    output logic       err,
    output logic [2:0] state_o
);

    localparam int              CW       = $clog2(MEM_TMO + 1);
    localparam logic [CW-1:0]   TMO_LAST = CW'(MEM_TMO - 1);

    state_t         state;
    state_t         state_next;
    logic [CW-1:0]  wait_cnt;
    logic           wait_expired;
    instr_class_t   cls;
    logic [3:0]     dec_alu_op;

    ctrl_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .cls    (cls),
        .alu_op (dec_alu_op)
    );

    // The last tolerated idle cycle: a miss here ends the access in ERR.
    assign wait_expired = !mem_ready && (wait_cnt == TMO_LAST);
    assign state_o      = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state_next != state) begin
            wait_cnt <= '0;
        end else if ((state == ST_FETCH || state == ST_MEM) && !mem_ready) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_FETCH: begin
                if (mem_ready)         state_next = ST_DECODE;
                else if (wait_expired) state_next = ST_ERR;
            end
            ST_DECODE: begin
                if (cls.illegal)                state_next = ST_ERR;
                else if (cls.halt)              state_next = ST_HALT;
                else if (cls.push || cls.call)  state_next = ST_SPADJ;
                else if (cls.pop || cls.ret)    state_next = ST_MEM;
                else                            state_next = ST_EXEC;
            end
            ST_EXEC: begin
                if (cls.rtype || cls.addi)      state_next = ST_WB;
                else if (cls.lw || cls.sw)      state_next = ST_MEM;
                else                            state_next = ST_FETCH;
            end
            ST_SPADJ: state_next = ST_MEM;
            ST_MEM: begin
                if (mem_ready)         state_next = (cls.lw || cls.pop) ? ST_WB : ST_FETCH;
                else if (wait_expired) state_next = ST_ERR;
            end
            ST_WB:    state_next = ST_FETCH;
            ST_HALT:  state_next = ST_HALT;
            ST_ERR:   state_next = ST_ERR;
            default:  state_next = ST_ERR;
        endcase
    end

    // Selects and strobes decode from state alone; only the commit enables of a
    // memory access are qualified by mem_ready so they land in the completing cycle.
    // Everything is forced low while rst_n is asserted.
    always_comb begin
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        regWrite    = 1'b0;
        spWrite     = 1'b0;
        regDst      = 1'b0;
        aluSrc      = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        memToReg    = 1'b0;
        jump        = 1'b0;
        bAndZ       = 1'b0;
        addrOp      = 1'b0;
        aOp2        = 1'b0;
        writeDataOp = 1'b0;
        wdOp2       = 1'b0;
        pcOp        = 1'b0;
        aluOp       = ALU_ADD;
        spOp        = SP_ADD;
        halted      = 1'b0;
        err         = 1'b0;
        if (rst_n) begin
            case (state)
                ST_FETCH: begin
                    memRead = 1'b1;
                    addrOp  = 1'b1;
                    aOp2    = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                ST_EXEC: begin
                    aluOp  = dec_alu_op;
                    regDst = cls.rtype;
                    aluSrc = cls.addi || cls.lw || cls.sw;
                    if (cls.beqz) begin
                        bAndZ    = zero;
                        pc_write = 1'b1;
                    end
                    if (cls.j) begin
                        jump     = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                ST_SPADJ: begin
                    spOp    = SP_SUB;
                    spWrite = 1'b1;
                end
                ST_MEM: begin
                    if (cls.lw) memRead  = 1'b1;
                    if (cls.sw) memWrite = 1'b1;
                    if (cls.push || cls.call) begin
                        memWrite    = 1'b1;
                        addrOp      = 1'b1;
                        writeDataOp = 1'b1;
                        wdOp2       = cls.push;
                    end
                    if (cls.pop || cls.ret) begin
                        memRead = 1'b1;
                        addrOp  = 1'b1;
                    end
                    if (mem_ready) begin
                        if (cls.call) begin
                            jump     = 1'b1;
                            pc_write = 1'b1;
                        end
                        if (cls.ret) begin
                            pcOp     = 1'b1;
                            pc_write = 1'b1;
                        end
                        if (cls.pop || cls.ret) begin
                            spOp    = SP_ADD;
                            spWrite = 1'b1;
                        end
                    end
                end
                ST_WB: begin
                    regWrite = 1'b1;
                    memToReg = cls.lw || cls.pop;
                    regDst   = cls.rtype;
                end
                ST_HALT: halted = 1'b1;
                ST_ERR:  err    = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
